// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: default widths,
// read/write encoding towards sram_ctrl and the arbiter FSM states.
package sram_arbiter_pkg;

    localparam int AW_DEF = 18;
    localparam int DW_DEF = 16;

    // sram_ctrl rw encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // The arbiter is busy from grant until the ack cycle has passed.
    function automatic logic state_is_busy(input state_t st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// One master port of the SRAM arbiter: request/command from the master,
// one-cycle ack and read data back from the arbiter.
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          req;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, rw, addr, wdata, input  ack, rdata);
    modport slave  (input  req, rw, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Combinational two-way grant. With both ports requesting, the port that
// was not served last wins (round-robin), or port 0 always wins when
// FIXED_PRI is set.
module rr_arb2 #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       sel
);

    // Pick the winning port index from the request vector.
    always_comb begin
        gnt = |req;
        sel = 1'b0;
        case (req)
            2'b10:   sel = 1'b1;
            2'b11:   sel = FIXED_PRI ? 1'b0 : ~last_gnt;
            default: sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single sram_ctrl transaction port between two masters.
// A grant latches the winner's command, pulses mem for one cycle, waits
// for sram_ctrl to return to ready and then acks the winner for one cycle.
// All outputs are registered.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave p0,
    sram_arbiter_if.slave p1,
    output logic          mem,
    output logic          rw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_f2s,
    input  logic          ready,
    input  logic [DW-1:0] data_s2f_r,
    output logic          busy
);

    state_t        state_reg, state_next;
    logic          sel_reg, sel_next;
    logic          last_gnt_reg, last_gnt_next;
    logic          first_wait_reg, first_wait_next;
    logic          mem_reg, mem_next;
    logic          rw_reg, rw_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [1:0]    ack_reg, ack_next;
    logic          busy_reg, busy_next;
    logic [1:0]    rdata_we;
    logic [DW-1:0] rdata_reg [2];

    logic          arb_gnt;
    logic          arb_sel;
    logic          win_rw;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_rr_arb2 (
        .req      ({p1.req, p0.req}),
        .last_gnt (last_gnt_reg),
        .gnt      (arb_gnt),
        .sel      (arb_sel)
    );

    assign win_rw    = arb_sel ? p1.rw    : p0.rw;
    assign win_addr  = arb_sel ? p1.addr  : p0.addr;
    assign win_wdata = arb_sel ? p1.wdata : p0.wdata;

    // State register; reset returns to IDLE with port 0 favoured first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= 1'b0;
            last_gnt_reg   <= 1'b1;
            first_wait_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            last_gnt_reg   <= last_gnt_next;
            first_wait_reg <= first_wait_next;
        end
    end

    // Next-state and next-output logic for the grant/issue/wait/ack sequence.
    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        last_gnt_next   = last_gnt_reg;
        first_wait_next = first_wait_reg;
        mem_next        = mem_reg;
        rw_next         = rw_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        ack_next        = 2'b00;
        rdata_we        = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                // No grant while sram_ctrl is still busy (e.g. after reset).
                if (ready && arb_gnt) begin
                    sel_next   = arb_sel;
                    rw_next    = win_rw;
                    addr_next  = win_addr;
                    wdata_next = win_wdata;
                    mem_next   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_next        = 1'b0;
                first_wait_next = 1'b1;
                state_next      = ST_WAIT;
            end
            ST_WAIT: begin
                // The controller is in rd1/wr1 during the first WAIT cycle,
                // so ready is only trusted from the second cycle on.
                if (first_wait_reg) begin
                    first_wait_next = 1'b0;
                end else if (ready) begin
                    if (rw_reg == RW_READ) begin
                        rdata_we[sel_reg] = 1'b1;
                    end
                    ack_next[sel_reg] = 1'b1;
                    state_next        = ST_ACK;
                end
            end
            ST_ACK: begin
                last_gnt_next = sel_reg;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = state_is_busy(state_next);
    end

    // Registered outputs towards sram_ctrl and the masters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_reg   <= 1'b0;
            rw_reg    <= RW_READ;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ack_reg   <= 2'b00;
            busy_reg  <= 1'b0;
        end else begin
            mem_reg   <= mem_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
        end
    end

    // Per-port read data: only the served port updates, others hold.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_reg[gi] <= '0;
            end else if (rdata_we[gi]) begin
                rdata_reg[gi] <= data_s2f_r;
            end
        end
    end

    assign mem      = mem_reg;
    assign rw       = rw_reg;
    assign addr     = addr_reg;
    assign data_f2s = wdata_reg;
    assign busy     = busy_reg;

    assign p0.ack   = ack_reg[0];
    assign p1.ack   = ack_reg[1];
    assign p0.rdata = rdata_reg[0];
    assign p1.rdata = rdata_reg[1];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. Two arbiters are built, instance 0 with
// round-robin and instance 1 with fixed priority, each driving its own
// behavioural sram_ctrl (idle -> rd1/wr1 -> rd2/wr2 -> idle) and SRAM.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // [instance][port]
    logic          p_req   [2][2];
    logic          p_rw    [2][2];
    logic [AW-1:0] p_addr  [2][2];
    logic [DW-1:0] p_wdata [2][2];
    logic          p_ack   [2][2];
    logic [DW-1:0] p_rdata [2][2];

    logic          mem_s   [2];
    logic          rw_s    [2];
    logic [AW-1:0] addr_s  [2];
    logic [DW-1:0] dataf_s [2];
    logic          ready_s [2];
    logic [DW-1:0] s2f_s   [2];
    logic          busy_s  [2];
    logic          stall   [2];

    logic [7:0]    peek_addr;
    logic [DW-1:0] peek_data [2];

    int total = 0;
    int bad   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            sram_arbiter_if #(.AW(AW), .DW(DW)) p0_if ();
            sram_arbiter_if #(.AW(AW), .DW(DW)) p1_if ();

            assign p0_if.req   = p_req[gi][0];
            assign p0_if.rw    = p_rw[gi][0];
            assign p0_if.addr  = p_addr[gi][0];
            assign p0_if.wdata = p_wdata[gi][0];
            assign p1_if.req   = p_req[gi][1];
            assign p1_if.rw    = p_rw[gi][1];
            assign p1_if.addr  = p_addr[gi][1];
            assign p1_if.wdata = p_wdata[gi][1];
            assign p_ack[gi][0]   = p0_if.ack;
            assign p_ack[gi][1]   = p1_if.ack;
            assign p_rdata[gi][0] = p0_if.rdata;
            assign p_rdata[gi][1] = p1_if.rdata;

            sram_arbiter #(
                .AW        (AW),
                .DW        (DW),
                .FIXED_PRI ((gi == 1) ? 1'b1 : 1'b0)
            ) dut (
                .clk        (clk),
                .reset      (reset),
                .p0         (p0_if),
                .p1         (p1_if),
                .mem        (mem_s[gi]),
                .rw         (rw_s[gi]),
                .addr       (addr_s[gi]),
                .data_f2s   (dataf_s[gi]),
                .ready      (ready_s[gi]),
                .data_s2f_r (s2f_s[gi]),
                .busy       (busy_s[gi])
            );

            // Behavioural sram_ctrl plus 256-word SRAM (low address byte).
            logic [1:0]    c_st;
            logic          c_rw;
            logic [AW-1:0] c_a;
            logic [DW-1:0] c_d;
            logic [DW-1:0] c_q;
            logic [DW-1:0] sram_m [256];

            assign ready_s[gi]   = (c_st == 2'd0) && !stall[gi];
            assign s2f_s[gi]     = c_q;
            assign peek_data[gi] = sram_m[peek_addr];

            always @(posedge clk or posedge reset) begin
                if (reset) begin
                    c_st <= 2'd0;
                    c_rw <= 1'b1;
                    c_a  <= '0;
                    c_d  <= '0;
                    c_q  <= '0;
                end else begin
                    case (c_st)
                        2'd0: if (mem_s[gi] && ready_s[gi]) begin
                            c_st <= 2'd1;
                            c_rw <= rw_s[gi];
                            c_a  <= addr_s[gi];
                            c_d  <= dataf_s[gi];
                        end
                        2'd1: c_st <= 2'd2;
                        2'd2: begin
                            c_st <= 2'd0;
                            if (c_a[AW-1:8] == '0) begin
                                if (c_rw) c_q <= sram_m[c_a[7:0]];
                                else      sram_m[c_a[7:0]] <= c_d;
                            end
                        end
                        default: c_st <= 2'd0;
                    endcase
                end
            end
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on one port, starting in an IDLE cycle (cycle 0).
    // Optionally changes wdata at cycle mod_cyc to probe the frozen copy.
    // Ends in the IDLE cycle after the ack with req dropped.
    task automatic run_txn(input int inst, input int port, input logic rw_i,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int mod_cyc, input logic [DW-1:0] mod_d,
                           output int ack_cyc, output int mem_cnt, output int busy_cnt);
        p_req[inst][port]   = 1'b1;
        p_rw[inst][port]    = rw_i;
        p_addr[inst][port]  = a;
        p_wdata[inst][port] = d;
        ack_cyc  = -1;
        mem_cnt  = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == mod_cyc) p_wdata[inst][port] = mod_d;
            if (mem_s[inst])  mem_cnt++;
            if (busy_s[inst]) busy_cnt++;
            if (p_ack[inst][port]) begin
                ack_cyc = c;
                break;
            end
        end
        p_req[inst][port] = 1'b0;
        tick();
    endtask

    int ac, mc, bc;
    int n_ack;
    int ack_port [8];
    int ack_cyc  [8];
    int p0_served;
    int cnt_a, cnt_b;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            stall[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                p_req[i][p]   = 1'b0;
                p_rw[i][p]    = RW_READ;
                p_addr[i][p]  = '0;
                p_wdata[i][p] = '0;
            end
        end
        peek_addr = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values on both instances
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_mem", i),   32'(mem_s[i]),        32'h0);
            check($sformatf("rst%0d_rw", i),    32'(rw_s[i]),         32'h1);
            check($sformatf("rst%0d_addr", i),  32'(addr_s[i]),       32'h0);
            check($sformatf("rst%0d_data", i),  32'(dataf_s[i]),      32'h0);
            check($sformatf("rst%0d_busy", i),  32'(busy_s[i]),       32'h0);
            check($sformatf("rst%0d_ack0", i),  32'(p_ack[i][0]),     32'h0);
            check($sformatf("rst%0d_ack1", i),  32'(p_ack[i][1]),     32'h0);
            check($sformatf("rst%0d_rd0", i),   32'(p_rdata[i][0]),   32'h0);
            check($sformatf("rst%0d_rd1", i),   32'(p_rdata[i][1]),   32'h0);
        end
        $display("reset values checked");
        tick();

        // 1: single write from p0
        run_txn(0, 0, RW_WRITE, 18'h00010, 16'hA5A5, 0, 16'h0, ac, mc, bc);
        check("t1_ack_cycle", 32'(ac), 32'd5);
        check("t1_mem_cycles", 32'(mc), 32'd1);
        check("t1_busy_cycles", 32'(bc), 32'd5);
        peek_addr = 8'h10;
        #1;
        check("t1_sram", 32'(peek_data[0]), 32'hA5A5);
        $display("txn p0 write 0x10 <= 0xA5A5 ack_cycle=%0d", ac);

        // 2: read-back from p1
        run_txn(0, 1, RW_READ, 18'h00010, 16'h0, 0, 16'h0, ac, mc, bc);
        check("t2_ack_cycle", 32'(ac), 32'd5);
        check("t2_p1_rdata", 32'(p_rdata[0][1]), 32'hA5A5);
        check("t2_p0_rdata_held", 32'(p_rdata[0][0]), 32'h0);
        $display("txn p1 read 0x10 => 0x%0h ack_cycle=%0d", p_rdata[0][1], ac);

        // 3: round-robin contention, both ports request continuously
        p_rw[0][0] = RW_READ; p_addr[0][0] = 18'h00010;
        p_rw[0][1] = RW_READ; p_addr[0][1] = 18'h00010;
        p_req[0][0] = 1'b1; p_req[0][1] = 1'b1;
        n_ack = 0; mc = 0; cnt_a = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (mem_s[0]) mc++;
            if (p_ack[0][0] && p_ack[0][1]) cnt_a++;
            for (int p = 0; p < 2; p++) begin
                if (p_ack[0][p] && n_ack < 8) begin
                    ack_port[n_ack] = p;
                    ack_cyc[n_ack]  = c;
                    n_ack++;
                end
            end
            if (n_ack >= 4) begin
                p_req[0][0] = 1'b0; p_req[0][1] = 1'b0;
                break;
            end
        end
        p_req[0][0] = 1'b0; p_req[0][1] = 1'b0;
        check("t3_ack_count", 32'(n_ack), 32'd4);
        check("t3_mem_count", 32'(mc), 32'd4);
        check("t3_double_ack", 32'(cnt_a), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ack) begin
                check($sformatf("t3_port_%0d", k), 32'(ack_port[k]), 32'(k % 2));
                check($sformatf("t3_cycle_%0d", k), 32'(ack_cyc[k]), 32'(5 + 6 * k));
                $display("txn rr grant %0d -> p%0d ack_cycle=%0d", k, ack_port[k], ack_cyc[k]);
            end
        end
        check("t3_p0_rdata", 32'(p_rdata[0][0]), 32'hA5A5);
        tick();

        // 4: fixed priority, p0 keeps winning until it drops req
        p_rw[1][0] = RW_WRITE; p_addr[1][0] = 18'h00040; p_wdata[1][0] = 16'h4444;
        p_rw[1][1] = RW_WRITE; p_addr[1][1] = 18'h00041; p_wdata[1][1] = 16'h1111;
        p_req[1][0] = 1'b1; p_req[1][1] = 1'b1;
        n_ack = 0; p0_served = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (p_ack[1][p] && n_ack < 8) begin
                    ack_port[n_ack] = p;
                    ack_cyc[n_ack]  = c;
                    n_ack++;
                end
            end
            if (p_ack[1][0]) begin
                p0_served++;
                if (p0_served == 3) p_req[1][0] = 1'b0;
            end
            if (p_ack[1][1]) begin
                p_req[1][1] = 1'b0;
                break;
            end
        end
        p_req[1][0] = 1'b0; p_req[1][1] = 1'b0;
        check("t4_ack_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ack) begin
                check($sformatf("t4_port_%0d", k), 32'(ack_port[k]), (k < 3) ? 32'd0 : 32'd1);
                check($sformatf("t4_cycle_%0d", k), 32'(ack_cyc[k]), 32'(5 + 6 * k));
                $display("txn fixed grant %0d -> p%0d ack_cycle=%0d", k, ack_port[k], ack_cyc[k]);
            end
        end
        peek_addr = 8'h41;
        #1;
        check("t4_sram_p1", 32'(peek_data[1]), 32'h1111);
        tick();

        // 5: reset during WAIT of a p0 write
        p_rw[0][0] = RW_WRITE; p_addr[0][0] = 18'h00020; p_wdata[0][0] = 16'hBEEF;
        p_req[0][0] = 1'b1;
        tick(); tick(); tick();   // cycle 3: second WAIT cycle
        check("t5_busy_before", 32'(busy_s[0]), 32'h1);
        reset = 1'b1;
        #1;
        check("t5_mem", 32'(mem_s[0]), 32'h0);
        check("t5_busy", 32'(busy_s[0]), 32'h0);
        check("t5_rw", 32'(rw_s[0]), 32'h1);
        check("t5_addr", 32'(addr_s[0]), 32'h0);
        check("t5_data", 32'(dataf_s[0]), 32'h0);
        check("t5_p0_rdata", 32'(p_rdata[0][0]), 32'h0);
        p_req[0][0] = 1'b0;
        cnt_b = 0;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (p_ack[0][0]) cnt_b++;
            tick();
        end
        check("t5_no_ack", 32'(cnt_b), 32'd0);
        $display("txn p0 write 0x20 aborted by reset, acks seen=%0d", cnt_b);
        run_txn(0, 0, RW_WRITE, 18'h00020, 16'h0BEE, 0, 16'h0, ac, mc, bc);
        check("t5_next_ack_cycle", 32'(ac), 32'd5);
        peek_addr = 8'h20;
        #1;
        check("t5_next_sram", 32'(peek_data[0]), 32'h0BEE);
        $display("txn p0 write 0x20 <= 0x0BEE ack_cycle=%0d", ac);

        // 6: master changes wdata after grant; frozen value is written
        run_txn(0, 0, RW_WRITE, 18'h00030, 16'h1234, 2, 16'hFFFF, ac, mc, bc);
        check("t6_ack_cycle", 32'(ac), 32'd5);
        peek_addr = 8'h30;
        #1;
        check("t6_sram", 32'(peek_data[0]), 32'h1234);
        $display("txn p0 write 0x30 <= 0x1234 (wdata changed to 0xFFFF) ack_cycle=%0d", ac);
        run_txn(0, 1, RW_READ, 18'h00030, 16'h0, 0, 16'h0, ac, mc, bc);
        check("t6_p1_rdata", 32'(p_rdata[0][1]), 32'h1234);
        check("t6_p0_rdata_held", 32'(p_rdata[0][0]), 32'h0);
        $display("txn p1 read 0x30 => 0x%0h ack_cycle=%0d", p_rdata[0][1], ac);

        // 7: controller not ready in IDLE -> no grant until it is
        stall[0] = 1'b1;
        p_rw[0][0] = RW_WRITE; p_addr[0][0] = 18'h00011; p_wdata[0][0] = 16'h5A5A;
        p_req[0][0] = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_s[0])  cnt_a++;
            if (busy_s[0]) cnt_b++;
        end
        check("t7_stall_mem", 32'(cnt_a), 32'd0);
        check("t7_stall_busy", 32'(cnt_b), 32'd0);
        stall[0] = 1'b0;
        run_txn(0, 0, RW_WRITE, 18'h00011, 16'h5A5A, 0, 16'h0, ac, mc, bc);
        check("t7_ack_cycle", 32'(ac), 32'd5);
        peek_addr = 8'h11;
        #1;
        check("t7_sram", 32'(peek_data[0]), 32'h5A5A);
        $display("txn p0 write 0x11 <= 0x5A5A after stall ack_cycle=%0d", ac);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
